// File: rtl/hdr_csum_cmd_gen.sv
// -----------------------------------------------------------------------------
// hdr_csum_cmd_gen
//
// Two-stage header pipeline placed in front of a checksum engine. Each beat
// carries a window of packet header bytes (network byte k at bits [8k+7:8k]).
//   Stage 1 captures the beat, locates the L3 header behind 0, 1 or 2 VLAN
//           tags (L = 14, 18 or 22) and flags plain 20-byte IPv4 headers.
//   Stage 2 optionally decrements the IPv4 TTL. It also emits a command for
//           the downstream checksum stage: enable, start bit index and
//           checksum byte index. Beats arriving with TTL 0/1 are flagged as
//           expired and are left untouched.
// Both stages advance together on en = !stream_out_valid || stream_out_ready,
// so a stalled output freezes the whole pipe and no beat can be lost.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ttl_dec_enable      quasi-static, 1 = decrement IPv4 TTL
//   stream_in_*         input beat (data/valid/ready)
//   stream_out_*        output beat (data/valid/ready)
//   csum_enable         downstream checksum recompute request for this beat
//   csum_start          bit index of first IPv4 header byte (L*8)
//   csum_offset         byte index of IPv4 checksum field (L+10)
//   ttl_expired         beat was IPv4 with TTL <= 1 while decrement enabled
//   stat_pkt/ipv4/ttl_exp  saturating counters of output handshakes
// -----------------------------------------------------------------------------
module hdr_csum_cmd_gen #(
   parameter int AVST_DATA_WIDTH = 600,
   parameter int AVST_ADDR_WIDTH = 9,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ttl_dec_enable,
   input  logic [AVST_DATA_WIDTH-1:0] stream_in_data,
   input  logic                       stream_in_valid,
   output logic                       stream_in_ready,
   output logic [AVST_DATA_WIDTH-1:0] stream_out_data,
   output logic                       stream_out_valid,
   input  logic                       stream_out_ready,
   output logic                       csum_enable,
   output logic [AVST_ADDR_WIDTH-1:0] csum_start,
   output logic [AVST_ADDR_WIDTH-1:0] csum_offset,
   output logic                       ttl_expired,
   output logic [CNT_WIDTH-1:0]       stat_pkt,
   output logic [CNT_WIDTH-1:0]       stat_ipv4,
   output logic [CNT_WIDTH-1:0]       stat_ttl_exp
);

   // L3 offset encoding carried from stage 1 to stage 2
   localparam logic [1:0] SEL_L14 = 2'd0;
   localparam logic [1:0] SEL_L18 = 2'd1;
   localparam logic [1:0] SEL_L22 = 2'd2;

   localparam logic [15:0] ETH_VLAN = 16'h8100;
   localparam logic [15:0] ETH_QINQ = 16'h88A8;
   localparam logic [15:0] ETH_IPV4 = 16'h0800;
   localparam logic [7:0]  IPV4_VER_IHL5 = 8'h45;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // network byte k of a header window
   function automatic logic [7:0] byte_at(input logic [AVST_DATA_WIDTH-1:0] d,
                                          input int unsigned             k);
      return d[8*k +: 8];
   endfunction

   logic                       en_s;
   logic [15:0]                etype0_s;
   logic [15:0]                etype1_s;
   logic [15:0]                etype2_s;
   logic [15:0]                etype_fin_s;
   logic [7:0]                 ip_byte_s;
   logic [1:0]                 l_sel_s;
   logic                       ipv4_s;

   logic                       s1_valid_r;
   logic [AVST_DATA_WIDTH-1:0] s1_data_r;
   logic [1:0]                 s1_sel_r;
   logic                       s1_ipv4_r;

   logic [7:0]                 l_s;
   logic [7:0]                 ttl_s;
   logic                       csum_en_s;
   logic                       expired_s;
   logic [AVST_DATA_WIDTH-1:0] data_s;
   logic                       out_ipv4_r;
   logic                       out_hs_s;

   assign en_s            = !stream_out_valid || stream_out_ready;
   assign stream_in_ready = en_s;
   assign out_hs_s        = stream_out_valid && stream_out_ready;

   // stage 1 parse: follow up to two VLAN tags to the final EtherType
   always_comb begin
      etype0_s    = {byte_at(stream_in_data, 12), byte_at(stream_in_data, 13)};
      etype1_s    = {byte_at(stream_in_data, 16), byte_at(stream_in_data, 17)};
      etype2_s    = {byte_at(stream_in_data, 20), byte_at(stream_in_data, 21)};
      etype_fin_s = etype0_s;
      ip_byte_s   = byte_at(stream_in_data, 14);
      l_sel_s     = SEL_L14;
      if (etype0_s == ETH_VLAN) begin
         etype_fin_s = etype1_s;
         ip_byte_s   = byte_at(stream_in_data, 18);
         l_sel_s     = SEL_L18;
      end else if ((etype0_s == ETH_QINQ) && (etype1_s == ETH_VLAN)) begin
         etype_fin_s = etype2_s;
         ip_byte_s   = byte_at(stream_in_data, 22);
         l_sel_s     = SEL_L22;
      end else begin
         etype_fin_s = etype0_s;
         ip_byte_s   = byte_at(stream_in_data, 14);
         l_sel_s     = SEL_L14;
      end
      // only version 4 with a 20-byte header (no options) qualifies
      ipv4_s = (etype_fin_s == ETH_IPV4) && (ip_byte_s == IPV4_VER_IHL5);
   end

   // stage 1 register; a bubble enters when no input is offered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= '0;
         s1_sel_r   <= SEL_L14;
         s1_ipv4_r  <= 1'b0;
      end else if (en_s) begin
         s1_valid_r <= stream_in_valid;
         s1_data_r  <= stream_in_data;
         s1_sel_r   <= l_sel_s;
         s1_ipv4_r  <= ipv4_s;
      end
   end

   // stage 2 select: L value and TTL byte (L+8) for the captured offset
   always_comb begin
      l_s   = 8'd14;
      ttl_s = byte_at(s1_data_r, 22);
      case (s1_sel_r)
         SEL_L18: begin
            l_s   = 8'd18;
            ttl_s = byte_at(s1_data_r, 26);
         end
         SEL_L22: begin
            l_s   = 8'd22;
            ttl_s = byte_at(s1_data_r, 30);
         end
         default: begin
            l_s   = 8'd14;
            ttl_s = byte_at(s1_data_r, 22);
         end
      endcase
   end

   // stage 2 rewrite: decrement TTL only when it stays non-zero afterwards
   always_comb begin
      csum_en_s = s1_ipv4_r && ttl_dec_enable && (ttl_s > 8'd1);
      expired_s = s1_ipv4_r && ttl_dec_enable && (ttl_s <= 8'd1);
      data_s    = s1_data_r;
      if (csum_en_s) begin
         case (s1_sel_r)
            SEL_L18: data_s[8*26 +: 8] = ttl_s - 8'd1;
            SEL_L22: data_s[8*30 +: 8] = ttl_s - 8'd1;
            default: data_s[8*22 +: 8] = ttl_s - 8'd1;
         endcase
      end else begin
         data_s = s1_data_r;
      end
   end

   // stage 2 / output register; holds everything while the output stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stream_out_valid <= 1'b0;
         stream_out_data  <= '0;
         csum_enable      <= 1'b0;
         csum_start       <= '0;
         csum_offset      <= '0;
         ttl_expired      <= 1'b0;
         out_ipv4_r       <= 1'b0;
      end else if (en_s) begin
         stream_out_valid <= s1_valid_r;
         stream_out_data  <= data_s;
         csum_enable      <= s1_valid_r && csum_en_s;
         csum_start       <= AVST_ADDR_WIDTH'({l_s, 3'b000});
         csum_offset      <= AVST_ADDR_WIDTH'(l_s + 8'd10);
         ttl_expired      <= s1_valid_r && expired_s;
         out_ipv4_r       <= s1_valid_r && s1_ipv4_r;
      end
   end

   // statistics: count on output handshake, stick at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_pkt     <= '0;
         stat_ipv4    <= '0;
         stat_ttl_exp <= '0;
      end else if (out_hs_s) begin
         if (stat_pkt != CNT_MAX) begin
            stat_pkt <= stat_pkt + CNT_ONE;
         end
         if (out_ipv4_r && (stat_ipv4 != CNT_MAX)) begin
            stat_ipv4 <= stat_ipv4 + CNT_ONE;
         end
         if (ttl_expired && (stat_ttl_exp != CNT_MAX)) begin
            stat_ttl_exp <= stat_ttl_exp + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_hdr_csum_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_hdr_csum_cmd_gen
//
// Directed scenarios followed by randomized traffic. Expected beats come from a
// byte-level header model and are queued at input acceptance, then compared in
// order at each output handshake. Counters, stall stability and ready are
// checked every cycle.
// -----------------------------------------------------------------------------
module tb_hdr_csum_cmd_gen;

   localparam int DW = 600;
   localparam int AW = 9;
   localparam int CW = 32;
   localparam int NB = DW / 8;

   typedef struct {
      logic [DW-1:0] data;
      logic          ce;
      logic [AW-1:0] st;
      logic [AW-1:0] off;
      logic          te;
      logic          v4;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ttl_en;
   logic [DW-1:0] din;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dout;
   logic          out_valid;
   logic          out_ready;
   logic          ce;
   logic [AW-1:0] cst;
   logic [AW-1:0] coff;
   logic          texp;
   logic [CW-1:0] s_pkt, s_ipv4, s_exp;

   int checks = 0;
   int errors = 0;

   exp_t          q[$];
   logic [DW-1:0] src_q[$];
   logic          rdy;
   logic          send_all;
   logic [CW-1:0] m_pkt, m_ipv4, m_exp;

   always #5 clk = ~clk;

   hdr_csum_cmd_gen #(.AVST_DATA_WIDTH(DW), .AVST_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ttl_dec_enable(ttl_en),
      .stream_in_data(din), .stream_in_valid(in_valid), .stream_in_ready(in_ready),
      .stream_out_data(dout), .stream_out_valid(out_valid), .stream_out_ready(out_ready),
      .csum_enable(ce), .csum_start(cst), .csum_offset(coff), .ttl_expired(texp),
      .stat_pkt(s_pkt), .stat_ipv4(s_ipv4), .stat_ttl_exp(s_exp)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference: walk the header as a byte array
   function automatic exp_t model(input logic [DW-1:0] d, input logic ten);
      exp_t       r;
      logic [7:0] b[NB];
      logic [15:0] et;
      int         l;
      logic [7:0] ttl;
      for (int i = 0; i < NB; i++) b[i] = d[8*i +: 8];
      et = {b[12], b[13]};
      l  = 14;
      if (et == 16'h8100) begin
         et = {b[16], b[17]};
         l  = 18;
      end else if (et == 16'h88A8 && {b[16], b[17]} == 16'h8100) begin
         et = {b[20], b[21]};
         l  = 22;
      end
      r.v4   = (et == 16'h0800) && (b[l] == 8'h45);
      ttl    = b[l + 8];
      r.data = d;
      r.st   = AW'(l * 8);
      r.off  = AW'(l + 10);
      r.ce   = 1'b0;
      r.te   = 1'b0;
      if (r.v4 && ten && ttl > 8'd1) begin
         r.ce = 1'b1;
         r.data[8*(l+8) +: 8] = ttl - 8'd1;
      end else if (r.v4 && ten) begin
         r.te = 1'b1;
      end
      return r;
   endfunction

   // kind: 0 untagged, 1 vlan, 2 qinq, 3 arp, 4 88A8 without inner 8100, 5 random
   function automatic logic [DW-1:0] gen(input int kind, input logic [7:0] vihl, input logic [7:0] ttl);
      logic [DW-1:0] d;
      int            l;
      for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'($urandom);
      l = 14;
      case (kind)
         0: d[8*12 +: 16] = {8'h00, 8'h08};
         1: begin d[8*12 +: 16] = {8'h00, 8'h81}; d[8*16 +: 16] = {8'h00, 8'h08}; l = 18; end
         2: begin d[8*12 +: 16] = {8'hA8, 8'h88}; d[8*16 +: 16] = {8'h00, 8'h81};
                  d[8*20 +: 16] = {8'h00, 8'h08}; l = 22; end
         3: d[8*12 +: 16] = {8'h06, 8'h08};
         4: begin d[8*12 +: 16] = {8'hA8, 8'h88}; d[8*16 +: 16] = {8'h00, 8'h08};
                  d[8*20 +: 16] = {8'h00, 8'h08}; l = 22; end
         default: l = -1;
      endcase
      if (l > 0) begin
         d[8*l +: 8]     = vihl;
         d[8*(l+8) +: 8] = ttl;
      end
      return d;
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 32'd1;
   endfunction

   // one clock: drive, observe handshakes before the edge, check after it
   task automatic tick();
      logic          acc, hs, stall;
      logic [DW-1:0] p_data;
      logic          p_ce, p_te;
      logic [AW-1:0] p_st, p_off;
      exp_t          e;
      if (src_q.size() > 0 && (send_all || $urandom_range(0, 3) != 0)) begin
         in_valid = 1'b1;
         din      = src_q[0];
      end else begin
         in_valid = 1'b0;
         din      = {19{32'($urandom)}};
      end
      out_ready = rdy;
      #1;
      acc   = in_valid && in_ready && rst_n;
      hs    = out_valid && out_ready && rst_n;
      stall = out_valid && !out_ready && rst_n;
      p_data = dout; p_ce = ce; p_te = texp; p_st = cst; p_off = coff;
      if (rst_n) chk("in_ready", in_ready, !out_valid || out_ready);
      if (hs) begin
         checks++;
         assert (q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_beat observed=1 expected=0");
         end
         m_pkt = sat_inc(m_pkt);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_data", p_data, e.data);
            chk("sb_csum_enable", p_ce, e.ce);
            chk("sb_csum_start", p_st, e.st);
            chk("sb_csum_offset", p_off, e.off);
            chk("sb_ttl_expired", p_te, e.te);
            if (e.v4) m_ipv4 = sat_inc(m_ipv4);
            if (e.te) m_exp  = sat_inc(m_exp);
         end
      end
      if (acc) begin
         q.push_back(model(din, ttl_en));
         void'(src_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
         chk("stat_pkt", s_pkt, m_pkt);
         chk("stat_ipv4", s_ipv4, m_ipv4);
         chk("stat_ttl_exp", s_exp, m_exp);
         if (stall) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", dout, p_data);
            chk("hold_side", {ce, texp, cst, coff}, {p_ce, p_te, p_st, p_off});
         end
      end
   endtask

   task automatic drain();
      rdy = 1'b1;
      for (int i = 0; i < 80 && (q.size() > 0 || src_q.size() > 0); i++) tick();
      checks++;
      assert (q.size() == 0 && src_q.size() == 0) else begin
         errors++;
         $error("FAIL drain_timeout observed=%0d expected=0", q.size() + src_q.size());
      end
      tick();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_data"}, dout, '0);
      chk({tag, "_side"}, {ce, texp, cst, coff}, '0);
      chk({tag, "_cnt"}, {s_pkt, s_ipv4, s_exp}, '0);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [7:0]    ttl_pick[6];
      logic [7:0]    ihl_pick[4];
      logic [CW-1:0] base;
      ttl_pick = '{8'd0, 8'd1, 8'd2, 8'd64, 8'd255, 8'd7};
      ihl_pick = '{8'h45, 8'h46, 8'h55, 8'h45};
      rst_n = 1'b0; ttl_en = 1'b1; in_valid = 1'b0; din = '0; out_ready = 1'b0;
      rdy = 1'b1; send_all = 1'b1; m_pkt = '0; m_ipv4 = '0; m_exp = '0;
      #3;
      chk_reset_state("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // untagged IPv4, TTL 64
      src_q.push_back(gen(0, 8'h45, 8'd64));
      tick();
      chk("r033_lat1", out_valid, 1'b0);
      tick();
      chk("r033_lat2", out_valid, 1'b1);
      chk("r033_ttl", dout[8*22 +: 8], 8'd63);
      chk("r033_ce", ce, 1'b1);
      chk("r033_start", cst, 9'd112);
      chk("r033_offset", coff, 9'd24);
      drain();

      // single VLAN, TTL 1
      d = gen(1, 8'h45, 8'd1);
      src_q.push_back(d);
      tick(); tick();
      chk("r034_exp", texp, 1'b1);
      chk("r034_ce", ce, 1'b0);
      chk("r034_data", dout, d);
      drain();
      chk("r034_stat", s_exp, 32'd1);

      // QinQ, TTL 10
      src_q.push_back(gen(2, 8'h45, 8'd10));
      tick(); tick();
      chk("r035_ttl", dout[8*30 +: 8], 8'd9);
      chk("r035_start", cst, 9'd176);
      chk("r035_offset", coff, 9'd32);
      drain();

      // ARP and IHL=6 are not IPv4 for this block; one IHL=5 beat is
      base = m_ipv4;
      d = gen(3, 8'h45, 8'd64);
      src_q.push_back(d);
      tick(); tick();
      chk("r036_arp_ce", ce, 1'b0);
      chk("r036_arp_data", dout, d);
      drain();
      d = gen(0, 8'h46, 8'd64);
      src_q.push_back(d);
      tick(); tick();
      chk("r036_ihl_ce", ce, 1'b0);
      chk("r036_ihl_data", dout, d);
      drain();
      src_q.push_back(gen(1, 8'h45, 8'd5));
      drain();
      chk("r036_stat_ipv4", s_ipv4, base + 32'd1);

      // 10 back-to-back beats under a toggling then stalled ready
      base = m_pkt;
      for (int i = 0; i < 10; i++) src_q.push_back(gen(i % 5, 8'h45, 8'(i + 1)));
      for (int c = 0; c < 40; c++) begin
         rdy = (c < 8) ? ((c % 2) == 0) : (c >= 13);
         tick();
      end
      drain();
      chk("r037_stat_pkt", s_pkt, base + 32'd10);

      // randomized traffic, TTL decrement on then off
      for (int ph = 0; ph < 2; ph++) begin
         ttl_en   = (ph == 0);
         send_all = 1'b0;
         for (int c = 0; c < 200; c++) begin
            if (src_q.size() < 3 && $urandom_range(0, 1) == 1)
               src_q.push_back(gen($urandom_range(0, 5), ihl_pick[$urandom_range(0, 3)],
                                   ttl_pick[$urandom_range(0, 5)]));
            rdy = ($urandom_range(0, 9) < 7);
            tick();
         end
         send_all = 1'b1;
         drain();
      end
      ttl_en = 1'b1;

      // reset with two beats in flight and output stalled
      src_q.push_back(gen(0, 8'h45, 8'd20));
      src_q.push_back(gen(1, 8'h45, 8'd20));
      tick(); tick();
      rdy = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk_reset_state("r038_async");
      q.delete(); src_q.delete();
      m_pkt = '0; m_ipv4 = '0; m_exp = '0;
      rdy = 1'b1;
      tick();
      rst_n = 1'b1;
      src_q.push_back(gen(2, 8'h45, 8'd33));
      tick();
      chk("r038_lat1", out_valid, 1'b0);
      tick();
      chk("r038_lat2", out_valid, 1'b1);
      chk("r038_ttl", dout[8*30 +: 8], 8'd32);
      tick();
      chk("r038_pkt", s_pkt, 32'd1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hdr_csum_cmd_gen.md
HDR_CSUM_CMD_GEN -- requirements
Module: hdr_csum_cmd_gen

Interface
REQ-001 SHALL have parameter AVST_DATA_WIDTH, default 600, header window width in bits; multiple of 8, >= 336.
REQ-002 SHALL have parameter AVST_ADDR_WIDTH, default 9, width of csum_start/csum_offset.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, statistics counter width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ttl_dec_enable  in  1  quasi-static; 1 = decrement IPv4 TTL.
REQ-007 stream_in_data  in  AVST_DATA_WIDTH  header window; network byte k at bits [8k+7:8k].
REQ-008 stream_in_valid  in  1  input beat valid.
REQ-009 stream_in_ready  out  1  input beat accepted when valid && ready.
REQ-010 stream_out_data  out  AVST_DATA_WIDTH  header window, TTL possibly rewritten.
REQ-011 stream_out_valid  out  1  output beat valid.
REQ-012 stream_out_ready  in  1  downstream accept.
REQ-013 csum_enable  out  1  downstream checksum stage shall recompute for this beat.
REQ-014 csum_start  out  AVST_ADDR_WIDTH  bit index of first IPv4 header byte.
REQ-015 csum_offset  out  AVST_ADDR_WIDTH  byte index of IPv4 checksum field.
REQ-016 ttl_expired  out  1  beat carried IPv4 TTL <= 1 with ttl_dec_enable.
REQ-017 stat_pkt, stat_ipv4, stat_ttl_exp  out  CNT_WIDTH each  statistics counters.

Function
REQ-018 Two-stage pipeline SHALL advance on en = !stream_out_valid || stream_out_ready; stream_in_ready SHALL equal en.
REQ-019 Latency SHALL be 2 cycles from accepted input to stream_out_valid; full throughput, one beat/cycle under continuous ready.
REQ-020 Stage 1 SHALL capture data, compute L3 byte offset L, IPv4 flag; bubble (valid=0) SHALL propagate when stream_in_valid=0 and en=1.
REQ-021 L rules on EtherType at bytes 12-13 (big-endian): 0x8100 -> check bytes 16-17, L=18; 0x88A8 with 0x8100 at 16-17 -> check bytes 20-21, L=22; otherwise L=14.
REQ-022 IPv4 flag SHALL be 1 only if final EtherType = 0x0800, byte L[7:4]=4, byte L[3:0]=5.
REQ-023 Stage 2 SHALL set csum_start=L*8, csum_offset=L+10 for every beat; csum_enable=IPv4 && ttl_dec_enable && TTL>1.
REQ-024 TTL = byte L+8; when csum_enable=1 stage 2 SHALL write TTL-1 into byte L+8, all other bytes unchanged.
REQ-025 IPv4 && ttl_dec_enable && TTL in {0,1} SHALL give ttl_expired=1, csum_enable=0, data unchanged.
REQ-026 Non-IPv4 or ttl_dec_enable=0 SHALL pass data unchanged, csum_enable=0, ttl_expired=0.
REQ-027 Sideband outputs SHALL be registered and aligned with stream_out_data; held stable while valid && !ready.
REQ-028 Counters SHALL increment on output handshake: stat_pkt every beat, stat_ipv4 if IPv4, stat_ttl_exp if ttl_expired; saturate at all-ones, no wrap.
REQ-029 Stall with both stages full SHALL lose no beat and duplicate no beat; input held off via ready=0.

Reset
REQ-030 rst_n low SHALL asynchronously clear both stage valids, stream_out_valid, csum_enable, ttl_expired, csum_start, csum_offset, stream_out_data, all counters to 0.
REQ-031 Reset mid-operation SHALL discard in-flight beats; first beat after release SHALL appear at cycle 2 after acceptance.
REQ-032 stream_in_ready SHALL be 1 during and after reset (pipeline empty).

Verification
REQ-033 Untagged IPv4, TTL=64, ttl_dec_enable=1 -> 2 cycles later valid, byte 22=63, csum_enable=1, csum_start=112, csum_offset=24.
REQ-034 Single VLAN 0x8100, inner 0x0800, TTL=1 -> ttl_expired=1, csum_enable=0, data unchanged, stat_ttl_exp=1.
REQ-035 QinQ 0x88A8/0x8100/0x0800, TTL=10 -> byte 30=9, csum_start=176, csum_offset=32.
REQ-036 ARP 0x0806 and IPv4 with IHL=6 -> csum_enable=0, data unchanged, stat_ipv4 counts only the IHL=5 case.
REQ-037 10 back-to-back beats, stream_out_ready toggled 1010... and held 0 for 5 cycles -> all 10 delivered in order, none dropped/duplicated, stat_pkt=10.
REQ-038 rst_n asserted with 2 beats in flight -> outputs 0 immediately; after release new beat emerges 2 cycles after acceptance; counters restart from 0.
